line_fill_unit: RTL

Memory-side stage directly downstream of cacheController. It accepts a line-refill request (req_cc2mem/adr_cc2mem), performs 2**WORD_OFFSET single-word reads on a backing-memory port, and returns each word as a one-cycle ack_mem2cc pulse with dat_mem2cc and the word index. The word order is critical-word-first with wrap-around, optionally linear. It also owns the one-word-at-a-time handshake that cacheController and its MSHR consume.

---
 rtl/mem_if_pkg.sv | 28 ++
 rtl/fill_order_gen.sv | 45 ++++
 rtl/line_fill_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-side memory interface.
// Holds the refill FSM state encoding and the address-slicing helpers
// used by cacheController and line_fill_unit. No ports.
package mem_if_pkg;

  // Byte offset inside a word; words are always 4 bytes.
  localparam int unsigned BYTE_OFFSET = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK,
    GAP,
    DONE
  } fill_state_t;

  // Number of words in a cache line.
  function automatic int unsigned words_per_line(input int unsigned word_offset);
    return 32'(1) << word_offset;
  endfunction

  // Lowest address bit of the line base (above word select and byte offset).
  function automatic int unsigned line_base_lsb(input int unsigned word_offset);
    return word_offset + BYTE_OFFSET;
  endfunction

endpackage

// File: rtl/fill_order_gen.sv
// Refill word-order generator: beat counter plus the combinational mapping
// from (start word, beat) to the current word index and backing address.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   beat_clr, beat_inc  clear / advance the beat counter
//   base, start_word    line base and first word of the burst
//   cur_word_c          start_word + beat, wrapping within the line
//   adr_c               word-aligned backing address of cur_word_c
//   last_c              current beat is the final word of the line
module fill_order_gen
  import mem_if_pkg::*;
#(
  parameter int unsigned ADR_WIDTH   = 32,
  parameter int unsigned WORD_OFFSET = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       beat_clr,
  input  logic                                       beat_inc,
  input  logic [ADR_WIDTH-BYTE_OFFSET-WORD_OFFSET-1:0] base,
  input  logic [WORD_OFFSET-1:0]                     start_word,
  output logic [WORD_OFFSET-1:0]                     cur_word_c,
  output logic [ADR_WIDTH-1:0]                       adr_c,
  output logic                                       last_c
);

  localparam int unsigned LAST_BEAT = words_per_line(WORD_OFFSET) - 1;

  logic [WORD_OFFSET-1:0] beat;

  // Beat counter: index of the word currently being fetched.
  always_ff @(posedge clk) begin
    if (rst || beat_clr) begin
      beat <= '0;
    end else if (beat_inc) begin
      beat <= beat + WORD_OFFSET'(1);
    end
  end

  // Addition wraps naturally in WORD_OFFSET bits, giving critical-word-first order.
  assign cur_word_c = start_word + beat;
  assign adr_c      = {base, cur_word_c, {BYTE_OFFSET{1'b0}}};
  assign last_c     = (beat == WORD_OFFSET'(LAST_BEAT));

endmodule

// File: rtl/line_fill_unit.sv
// Line refill engine between cacheController and a single-word backing port.
// Fetches all words of the missed line (critical word first, or linear) and
// returns them one at a time as single-cycle acks separated by a low cycle.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_cc2mem, adr_cc2mem         refill request and miss address
//   ack_mem2cc, dat_mem2cc,
//   word_mem2cc                    returned word pulse, data and word index
//   fill_busy                      refill in progress
//   bk_req, bk_adr, bk_gnt         backing read request handshake
//   bk_rvalid, bk_rdata            backing read return
module line_fill_unit
  import mem_if_pkg::*;
#(
  parameter int unsigned ADR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WORD_OFFSET = 2,
  parameter bit          CRIT_FIRST  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_cc2mem,
  input  logic [ADR_WIDTH-1:0]   adr_cc2mem,
  output logic                   ack_mem2cc,
  output logic [DATA_WIDTH-1:0]  dat_mem2cc,
  output logic [WORD_OFFSET-1:0] word_mem2cc,
  output logic                   fill_busy,
  output logic                   bk_req,
  output logic [ADR_WIDTH-1:0]   bk_adr,
  input  logic                   bk_gnt,
  input  logic                   bk_rvalid,
  input  logic [DATA_WIDTH-1:0]  bk_rdata
);

  localparam int unsigned BASE_LSB = line_base_lsb(WORD_OFFSET);
  localparam int unsigned BASE_W   = ADR_WIDTH - BASE_LSB;

  fill_state_t            state;
  logic [BASE_W-1:0]      base;
  logic [WORD_OFFSET-1:0] start_word;
  logic                   aborting;

  logic [BASE_W-1:0]      req_base_c;
  logic [WORD_OFFSET-1:0] req_start_c;
  logic [BASE_W-1:0]      gen_base_c;
  logic [WORD_OFFSET-1:0] gen_start_c;
  logic                   beat_clr_c;
  logic                   beat_inc_c;
  logic                   last_beat_c;
  logic [WORD_OFFSET-1:0] cur_word_c;
  logic [ADR_WIDTH-1:0]   beat_adr_c;
  logic                   unused_byte_bits;

  // Line base and starting word taken straight from the incoming request.
  assign req_base_c       = adr_cc2mem[ADR_WIDTH-1:BASE_LSB];
  assign req_start_c      = CRIT_FIRST ? adr_cc2mem[BASE_LSB-1:BYTE_OFFSET] : '0;
  assign unused_byte_bits = ^adr_cc2mem[BYTE_OFFSET-1:0];

  // In IDLE the generator sees the live request so the first bk_adr is
  // registered in the same cycle the request is accepted.
  assign gen_base_c  = (state == IDLE) ? req_base_c  : base;
  assign gen_start_c = (state == IDLE) ? req_start_c : start_word;
  assign beat_clr_c  = (state == IDLE);
  assign beat_inc_c  = (state == GAP) && req_cc2mem && !last_beat_c;

  fill_order_gen #(
    .ADR_WIDTH  (ADR_WIDTH),
    .WORD_OFFSET(WORD_OFFSET)
  ) u_order (
    .clk       (clk),
    .rst       (rst),
    .beat_clr  (beat_clr_c),
    .beat_inc  (beat_inc_c),
    .base      (gen_base_c),
    .start_word(gen_start_c),
    .cur_word_c(cur_word_c),
    .adr_c     (beat_adr_c),
    .last_c    (last_beat_c)
  );

  // Refill FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base        <= '0;
      start_word  <= '0;
      aborting    <= 1'b0;
      ack_mem2cc  <= 1'b0;
      dat_mem2cc  <= '0;
      word_mem2cc <= '0;
      fill_busy   <= 1'b0;
      bk_req      <= 1'b0;
      bk_adr      <= '0;
    end else begin
      ack_mem2cc <= 1'b0;
      case (state)
        IDLE: begin
          if (req_cc2mem) begin
            base       <= req_base_c;
            start_word <= req_start_c;
            aborting   <= 1'b0;
            fill_busy  <= 1'b1;
            bk_req     <= 1'b1;
            bk_adr     <= beat_adr_c;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // A grant always has to be followed by its rvalid, even when aborting.
          if (bk_req && bk_gnt) begin
            bk_req   <= 1'b0;
            aborting <= !req_cc2mem;
            state    <= WAIT;
          end else if (!req_cc2mem) begin
            bk_req    <= 1'b0;
            fill_busy <= 1'b0;
            state     <= IDLE;
          end else if (!bk_req) begin
            // Entered from GAP: the advanced beat address is valid now.
            bk_req <= 1'b1;
            bk_adr <= beat_adr_c;
          end
        end
        WAIT: begin
          if (bk_rvalid) begin
            if (aborting || !req_cc2mem) begin
              fill_busy <= 1'b0;
              state     <= IDLE;
            end else begin
              ack_mem2cc  <= 1'b1;
              dat_mem2cc  <= bk_rdata;
              word_mem2cc <= cur_word_c;
              state       <= ACK;
            end
          end else if (!req_cc2mem) begin
            aborting <= 1'b1;
          end
        end
        ACK: begin
          if (!req_cc2mem) begin
            fill_busy <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= GAP;
          end
        end
        GAP: begin
          if (!req_cc2mem) begin
            fill_busy <= 1'b0;
            state     <= IDLE;
          end else if (last_beat_c) begin
            state <= DONE;
          end else begin
            state <= ISSUE;
          end
        end
        DONE: begin
          // Wait for the request to drop so a held request cannot refill again.
          if (!req_cc2mem) begin
            fill_busy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
